delay_line_ctrl: RTL and testbench

//   Runtime-programmable delay line for LENGTH-bit samples.
//   - Delay D is set over a cfg handshake, 1 <= D <= MAX_DELAY.
//   - A valid tag travels with every sample.
//   - An FSM (IDLE/FLUSH/RUN) sequences reconfiguration so stale samples never reach y.
//   - Replaces fixed-depth shift delays where the delay must change in-system.

---
 rtl/delay_line_ctrl.sv | 118 +++++++++++
 tb/tb_delay_line_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// Runtime-programmable delay line: circular buffer of tagged samples, reconfigured
// through IDLE/FLUSH/RUN sequencing. Define DELAY_OCC_EN to add the occ occupancy port.
module delay_line_ctrl #(
  parameter int unsigned LENGTH    = 3,
  parameter int unsigned MAX_DELAY = 8,
  localparam int unsigned CW       = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW-1:0]     cfg_delay,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] x,
  output logic              out_valid,
  output logic [LENGTH-1:0] y,
  output logic              busy
`ifdef DELAY_OCC_EN
  ,
  output logic [CW-1:0]     occ
`endif
);

  localparam int unsigned PW = $clog2(MAX_DELAY);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cur_delay;
  logic [CW-1:0]   flush_cnt;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   wp_next;
  logic [PW-1:0]   rd;
  logic [CW:0]     rd_sum;
  logic [LENGTH:0] mem [MAX_DELAY];
  logic            cfg_legal;
  logic            cfg_acc;
  logic            cfg_load;

  assign cfg_ready = (state != FLUSH);
  assign busy      = (state == FLUSH);

  always_comb begin
    cfg_legal = (cfg_delay != '0) && (cfg_delay <= CW'(MAX_DELAY));
    cfg_acc   = cfg_valid && cfg_ready;
    cfg_load  = cfg_acc && cfg_legal;
    // read slot lags the write pointer by cur_delay, modulo the buffer depth
    rd_sum = (CW+1)'(wp) + (CW+1)'(MAX_DELAY) - (CW+1)'(cur_delay);
    if (rd_sum >= (CW+1)'(MAX_DELAY))
      rd_sum = rd_sum - (CW+1)'(MAX_DELAY);
    rd      = PW'(rd_sum);
    wp_next = (wp == PW'(MAX_DELAY - 1)) ? '0 : wp + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_delay <= '0;
      flush_cnt <= '0;
      wp        <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int unsigned i = 0; i < MAX_DELAY; i++)
        mem[i] <= '0;
    end else begin
      cfg_err   <= cfg_acc && !cfg_legal;
      out_valid <= 1'b0;
      y         <= '0;
      if (cfg_load) begin
        cur_delay <= cfg_delay;
        flush_cnt <= cfg_delay;
        state     <= FLUSH;
      end else begin
        unique case (state)
          FLUSH: begin
            // clearing D consecutive slots from wp covers exactly the slots read in the first D RUN cycles
            mem[wp][LENGTH] <= 1'b0;
            wp              <= wp_next;
            flush_cnt       <= flush_cnt - CW'(1);
            if (flush_cnt == CW'(1))
              state <= RUN;
          end
          RUN: begin
            mem[wp]   <= {in_valid, x};
            wp        <= wp_next;
            out_valid <= mem[rd][LENGTH];
            y         <= mem[rd][LENGTH] ? mem[rd][LENGTH-1:0] : '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DELAY_OCC_EN
  logic occ_inc;
  logic occ_dec;

  always_comb begin
    occ_inc = (state == RUN) && !cfg_load && in_valid;
    occ_dec = (state == RUN) && !cfg_load && mem[rd][LENGTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occ <= '0;
    else if (cfg_load)
      occ <= '0;
    else if (occ_inc && !occ_dec)
      occ <= occ + CW'(1);
    else if (occ_dec && !occ_inc)
      occ <= occ - CW'(1);
  end
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: a queue scoreboard holds samples in flight and
// each posedge pops the one due at y; occ is checked only when DELAY_OCC_EN is defined.
module tb_delay_line_ctrl;

  localparam int unsigned LENGTH    = 3;
  localparam int unsigned MAX_DELAY = 8;
  localparam int unsigned CW        = $clog2(MAX_DELAY + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CW-1:0]     cfg_delay;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_err;
  logic              in_valid;
  logic [LENGTH-1:0] x;
  logic              out_valid;
  logic [LENGTH-1:0] y;
  logic              busy;
`ifdef DELAY_OCC_EN
  logic [CW-1:0]     occ;
`endif

  delay_line_ctrl #(.LENGTH(LENGTH), .MAX_DELAY(MAX_DELAY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_delay (cfg_delay),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y         (y),
    .busy      (busy)
`ifdef DELAY_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_FLUSH, M_RUN} mstate_t;

  int unsigned       n_pass  = 0;
  int unsigned       n_fail  = 0;
  int unsigned       n_total = 0;
  mstate_t           mst;
  int unsigned       md;
  int unsigned       mcnt;
  logic [LENGTH:0]   sb[$];
  logic              e_ov;
  logic              e_err;
  logic [LENGTH-1:0] e_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE;
    md  = 0;
    mcnt = 0;
    sb.delete();
  endtask

  // One clock: drive inputs, advance the reference model, compare after the edge.
  task automatic cyc(input logic iv, input logic [LENGTH-1:0] xv,
                     input logic cv, input logic [CW-1:0] cd);
    int unsigned     dval;
    int unsigned     nvalid;
    logic            acc;
    logic            legal;
    logic [LENGTH:0] e;
    in_valid  = iv;
    x         = xv;
    cfg_valid = cv;
    cfg_delay = cd;
    dval  = int'(cd);
    acc   = cv && (mst != M_FLUSH);
    legal = (dval >= 1) && (dval <= MAX_DELAY);
    e_ov  = 1'b0;
    e_y   = '0;
    e_err = 1'b0;
    if (acc && legal) begin
      md   = dval;
      mcnt = dval;
      mst  = M_FLUSH;
      sb.delete();
    end else begin
      e_err = acc;
      if (mst == M_FLUSH) begin
        if (mcnt == 1) mst = M_RUN;
        else mcnt--;
      end else if (mst == M_RUN) begin
        sb.push_back({iv, xv});
        if (sb.size() > md) begin
          e    = sb.pop_front();
          e_ov = e[LENGTH];
          e_y  = e[LENGTH] ? e[LENGTH-1:0] : '0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("y",         32'(y),         32'(e_y));
    check("cfg_err",   32'(cfg_err),   32'(e_err));
    check("busy",      32'(busy),      32'(mst == M_FLUSH));
    check("cfg_ready", 32'(cfg_ready), 32'(mst != M_FLUSH));
`ifdef DELAY_OCC_EN
    nvalid = 0;
    foreach (sb[i]) if (sb[i][LENGTH]) nvalid++;
    check("occ", 32'(occ), nvalid);
`else
    nvalid = 0;
`endif
    cfg_valid = 1'b0;
  endtask

  task automatic smp(input logic iv, input logic [LENGTH-1:0] xv);
    cyc(iv, xv, 1'b0, '0);
  endtask

  task automatic cfg(input logic [CW-1:0] d);
    cyc(1'b0, '0, 1'b1, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    cfg_valid = 1'b0;
    cfg_delay = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y",         32'(y),         32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
`ifdef DELAY_OCC_EN
    check("rst_occ",       32'(occ),       32'd0);
`endif
    rst_n = 1'b1;

    // IDLE ignores in_valid
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd6);

    // D=3 with a continuous stream; samples offered during FLUSH are ignored
    cfg(4'd3);
    for (int i = 1; i <= 14; i++) smp(1'b1, 3'(i));

    // D=MAX_DELAY: every slot used, pointer wraps seamlessly
    cfg(4'd8);
    for (int i = 0; i < 28; i++) smp(1'b1, 3'(i * 3 + 1));
    for (int i = 0; i < 9; i++) smp(1'b0, 3'd7);

    // D=4 with gaps in the stream
    cfg(4'd4);
    for (int i = 0; i < 4; i++) smp(1'b0, '0);
    smp(1'b1, 3'd2);
    smp(1'b0, 3'd3);
    smp(1'b1, 3'd4);
    smp(1'b1, 3'd5);
    smp(1'b0, 3'd6);
    for (int i = 0; i < 5; i++) smp(1'b0, '0);

    // D=1: y follows x one cycle later
    cfg(4'd1);
    smp(1'b1, 3'd0);
    for (int i = 0; i < 6; i++) smp(1'b1, 3'(7 - i));

    // Mid-stream reconfiguration D=5 -> D=2; the sample in the accept cycle is dropped
    cfg(4'd5);
    for (int i = 0; i < 15; i++) smp(1'b1, 3'(i));
    cyc(1'b1, 3'd6, 1'b1, 4'd2);
    for (int i = 0; i < 8; i++) smp(1'b1, 3'(i + 1));

    // Illegal delays pulse cfg_err and leave the running stream intact
    cyc(1'b1, 3'd2, 1'b1, 4'd0);
    smp(1'b1, 3'd3);
    cyc(1'b1, 3'd4, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) smp(1'b1, 3'(i + 5));

    // Reset asserted mid-FLUSH aborts to IDLE
    cfg(4'd6);
    smp(1'b1, 3'd1);
    smp(1'b1, 3'd1);
    #3 rst_n = 1'b0;
    #1;
    check("midflush_out_valid", 32'(out_valid), 32'd0);
    check("midflush_busy",      32'(busy),      32'd0);
    check("midflush_cfg_ready", 32'(cfg_ready), 32'd1);
    check("midflush_y",         32'(y),         32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd6);
    cfg(4'd2);
    for (int i = 0; i < 6; i++) smp(1'b1, 3'(i + 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
